// File: rtl/env_io_multi.sv
// Z80 I/O-mapped test environment: command pulses, console FIFO, interrupt countdowns.
// The watchdog is only built when ENV_IO_MULTI_TIMEOUT_EN is defined.
module env_io_multi #(
    parameter logic [7:0]  BASE_ADDR = 8'h80,
    parameter int unsigned NUM_INT   = 2,
    parameter int unsigned BUF_DEPTH = 16,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] addr,
    input  logic [7:0] DO,
    inout  wire  [7:0] DI,
    output logic       int_n,
    output logic       test_pass,
    output logic       test_fail,
    output logic       dump_on,
    output logic       dump_off,
    output logic       timeout_err,
    output logic [7:0] con_data,
    output logic       con_valid,
    input  logic       con_ready
);
    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = AW + 1;

    if (NUM_INT < 1 || NUM_INT > 8 || BUF_DEPTH < 4 || BUF_DEPTH > 256 ||
        (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || TIMEOUT_W < 16 || TIMEOUT_W > 32)
    begin : g_bad_param
        $error("env_io_multi: parameter out of range");
    end

    logic       hit, wr_act, wr_act_q, wr_stb, rd_act, chan_sel;
    logic       cmd_wr, st_wr, tmo_rise;
    logic [3:0] off;
    logic [7:0] rdata, wd_rdata;

    assign hit      = addr[7:4] == BASE_ADDR[7:4];
    assign off      = addr[3:0];
    assign wr_act   = !iorq_n && !wr_n && hit;
    assign rd_act   = !iorq_n && !rd_n && hit;
    // One write per I/O cycle: act only on the first cycle of the strobe.
    assign wr_stb   = wr_act && !wr_act_q;
    assign chan_sel = off[3] && ({29'd0, off[2:0]} < NUM_INT);
    assign cmd_wr   = wr_stb && off == 4'h0;
    assign st_wr    = wr_stb && off == 4'h5;

    // Console FIFO
    logic [7:0]    fifo_mem [BUF_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [8:0]    count_ext;
    logic          push_req, push_ok, pop, full, ovf_q, cmd_err_q;

    assign full      = count_q == CW'(BUF_DEPTH);
    assign con_valid = count_q != '0;
    assign con_data  = fifo_mem[rd_ptr_q];
    assign pop       = con_valid && con_ready;
    assign push_req  = wr_stb && off == 4'h1;
    assign push_ok   = push_req && (!full || pop);
    assign count_ext = 9'(count_q);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n && push_ok) fifo_mem[wr_ptr_q] <= DO;
    end

    // Interrupt countdown channels
    logic [7:0]         cnt_q [NUM_INT];
    logic [NUM_INT-1:0] pending_q, pending_d, pend_set, pend_clr, ch_wr;

    always_comb begin
        ch_wr    = '0;
        pend_set = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            ch_wr[i]    = wr_stb && chan_sel && off[2:0] == 3'(i);
            pend_set[i] = cnt_q[i] == 8'd1 && !ch_wr[i];
        end
        pend_clr  = (wr_stb && off == 4'h6) ? DO[NUM_INT-1:0] : '0;
        pending_d = (pending_q & ~pend_clr) | pend_set;
    end

`ifdef ENV_IO_MULTI_TIMEOUT_EN
    localparam logic [31:0] MaxMask = (TIMEOUT_W >= 32) ? 32'hFFFF_FFFF :
                                      ((32'd1 << TIMEOUT_W) - 32'd1);
    logic [7:0]           ctl_q;
    logic [31:0]          max_q, max_d;
    logic [TIMEOUT_W-1:0] cur_q;
    logic                 wd_clr, err_q, err_d;

    assign wd_clr      = wr_stb && off == 4'h2 && DO[1];
    assign err_d       = (st_wr && DO[0]) ? 1'b0 : ((32'(cur_q) >= max_q) ? 1'b1 : err_q);
    assign tmo_rise    = err_d && !err_q;
    assign timeout_err = err_q;

    always_comb begin
        max_d = max_q;
        if (wr_stb && !chan_sel) begin
            case (off)
                4'h3:    max_d[7:0]   = DO;
                4'h4:    max_d[15:8]  = DO;
                4'hC:    max_d[23:16] = DO;
                4'hD:    max_d[31:24] = DO;
                default: ;
            endcase
        end
        max_d = max_d & MaxMask;
    end

    always_comb begin
        wd_rdata = 8'h00;
        case (off)
            4'h2:    wd_rdata = ctl_q;
            4'h3:    wd_rdata = max_q[7:0];
            4'h4:    wd_rdata = max_q[15:8];
            4'hC:    wd_rdata = (TIMEOUT_W > 16) ? max_q[23:16] : 8'hFF;
            4'hD:    wd_rdata = (TIMEOUT_W > 16) ? max_q[31:24] : 8'hFF;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctl_q <= 8'h01;
            max_q <= 32'd10000;
            cur_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr_stb && off == 4'h2) ctl_q <= DO & 8'hFD;
            max_q <= max_d;
            if (wd_clr) cur_q <= '0;
            else if (ctl_q[0] && cur_q != '1) cur_q <= cur_q + TIMEOUT_W'(1);
            err_q <= err_d;
        end
    end
`else
    assign tmo_rise    = 1'b0;
    assign timeout_err = 1'b0;
    assign wd_rdata    = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // A strobe already low at release must not count as a new access.
            wr_act_q  <= wr_act;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cmd_err_q <= 1'b0;
            pending_q <= '0;
            int_n     <= 1'b1;
            test_pass <= 1'b0;
            test_fail <= 1'b0;
            dump_on   <= 1'b0;
            dump_off  <= 1'b0;
            for (int i = 0; i < NUM_INT; i++) cnt_q[i] <= '0;
        end else begin
            wr_act_q  <= wr_act;
            test_pass <= cmd_wr && DO == 8'd1;
            test_fail <= (cmd_wr && DO == 8'd2) || tmo_rise;
            dump_on   <= cmd_wr && DO == 8'd3;
            dump_off  <= cmd_wr && DO == 8'd4;
            if (cmd_wr && !(DO inside {[8'd1:8'd4]})) cmd_err_q <= 1'b1;
            else if (st_wr && DO[2]) cmd_err_q <= 1'b0;
            if (push_req && !push_ok) ovf_q <= 1'b1;
            else if (st_wr && DO[1]) ovf_q <= 1'b0;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            pending_q <= pending_d;
            int_n     <= ~|pending_d;
            for (int i = 0; i < NUM_INT; i++) begin
                if (ch_wr[i]) cnt_q[i] <= DO;
                else if (cnt_q[i] != 8'd0) cnt_q[i] <= cnt_q[i] - 8'd1;
            end
        end
    end

    always_comb begin
        rdata = 8'hFF;
        if (chan_sel) begin
            for (int i = 0; i < NUM_INT; i++) begin
                if (off[2:0] == 3'(i)) rdata = cnt_q[i];
            end
        end else begin
            case (off)
                4'h1:                         rdata = count_ext[8] ? 8'hFF : count_ext[7:0];
                4'h2, 4'h3, 4'h4, 4'hC, 4'hD: rdata = wd_rdata;
                4'h5:    rdata = {4'h0, |pending_q, cmd_err_q, ovf_q, timeout_err};
                4'h7:    rdata = 8'(pending_q);
                default: ;
            endcase
        end
    end

    assign DI = rd_act ? rdata : 8'hzz;

endmodule

// File: tb/tb_env_io_multi.sv
// Self-checking bench for env_io_multi; console bytes are checked through a scoreboard queue.
module tb_env_io_multi;
    logic       clk = 1'b0;
    logic       reset_n, iorq_n, rd_n, wr_n, con_ready;
    logic [7:0] addr, DO;
    wire  [7:0] DI;
    logic       int_n, test_pass, test_fail, dump_on, dump_off, timeout_err, con_valid;
    logic [7:0] con_data;

    int n_checks = 0;
    int n_fail   = 0;
    int pass_cnt = 0, fail_cnt = 0, don_cnt = 0, doff_cnt = 0, pop_cnt = 0;
    logic [7:0] con_exp [$];

    env_io_multi #(.BASE_ADDR(8'h80), .NUM_INT(2), .BUF_DEPTH(4), .TIMEOUT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .DO(DO), .DI(DI), .int_n(int_n), .test_pass(test_pass),
        .test_fail(test_fail), .dump_on(dump_on), .dump_off(dump_off),
        .timeout_err(timeout_err), .con_data(con_data), .con_valid(con_valid),
        .con_ready(con_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled on the falling edge; inputs change 2ns after the rising edge.
    always @(negedge clk) begin
        if (test_pass) pass_cnt++;
        if (test_fail) fail_cnt++;
        if (dump_on)   don_cnt++;
        if (dump_off)  doff_cnt++;
        if (con_valid && con_ready) begin
            pop_cnt++;
            if (con_exp.size() == 0) check("con_extra", 32'(con_exp.size()), 1);
            else check("con_data", {24'd0, con_data}, {24'd0, con_exp.pop_front()});
        end
    end

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold);
        @(posedge clk); #2;
        addr = a; DO = d; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (hold) @(posedge clk);
        #2; iorq_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #2;
        addr = a; iorq_n = 1'b0; rd_n = 1'b0;
        #3; d = DI;
        @(posedge clk); #2;
        iorq_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        io_read(a, d);
        check(tag, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (con_exp.size() != 0 && k < 50) begin
            @(negedge clk); k++;
        end
        check(tag, 32'(con_exp.size()), 0);
    endtask

    initial begin
        logic [7:0] hi_str [3];
        int base, k;
        hi_str[0] = 8'h48; hi_str[1] = 8'h49; hi_str[2] = 8'h0A;
        reset_n = 1'b0; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = 8'h00; DO = 8'h00; con_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_int_n", int_n, 1);
        check("rst_con_valid", con_valid, 0);
        check("rst_pulses", {test_pass, test_fail, dump_on, dump_off}, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(posedge clk); #2; reset_n = 1'b1;
        read_chk("rst_occ", 8'h81, 8'h00);
        read_chk("rst_status", 8'h85, 8'h00);
        read_chk("rst_pending", 8'h87, 8'h00);
        read_chk("rst_ch0", 8'h88, 8'h00);
        read_chk("unmapped_off0", 8'h80, 8'hFF);
        read_chk("unmapped_off15", 8'h8F, 8'hFF);

        // Long write strobe yields one pulse only
        io_write(8'h80, 8'h01, 5);
        repeat (3) @(negedge clk);
        check("long_wr_pass", pass_cnt, 1);
        check("long_wr_nofail", fail_cnt, 0);
        io_write(8'h80, 8'h02, 1);
        io_write(8'h80, 8'h03, 1);
        io_write(8'h80, 8'h04, 1);
        repeat (3) @(negedge clk);
        check("cmd_counts", {pass_cnt[7:0], fail_cnt[7:0], don_cnt[7:0], doff_cnt[7:0]},
              32'h01010101);
        io_write(8'h80, 8'h07, 1);
        read_chk("cmd_err", 8'h85, 8'h04);
        io_write(8'h85, 8'h04, 1);
        read_chk("cmd_err_clr", 8'h85, 8'h00);
        io_write(8'h8E, 8'h55, 1);
        read_chk("unmapped_wr", 8'h8E, 8'hFF);

        // Console stream
        for (int i = 0; i < 3; i++) begin
            io_write(8'h81, hi_str[i], 1);
            con_exp.push_back(hi_str[i]);
        end
        read_chk("hi_occ", 8'h81, 8'h03);
        @(posedge clk); #2; con_ready = 1'b1;
        drain("hi_drain");
        @(negedge clk);
        check("hi_valid_low", con_valid, 0);
        check("hi_pops", pop_cnt, 3);
        @(posedge clk); #2; con_ready = 1'b0;

        // Overflow with a 4-deep FIFO, then push+pop while full
        for (int i = 0; i < 5; i++) begin
            io_write(8'h81, 8'(8'h11 * (i + 1)), 1);
            if (i < 4) con_exp.push_back(8'(8'h11 * (i + 1)));
        end
        read_chk("ovf_occ", 8'h81, 8'h04);
        read_chk("ovf_status", 8'h85, 8'h02);
        io_write(8'h85, 8'h02, 1);
        read_chk("ovf_clr", 8'h85, 8'h00);
        @(posedge clk); #2;
        addr = 8'h81; DO = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0; con_ready = 1'b1;
        con_exp.push_back(8'h5A);
        @(posedge clk); #2; iorq_n = 1'b1; wr_n = 1'b1;
        drain("full_pp_drain");
        read_chk("full_pp_no_ovf", 8'h85, 8'h00);
        check("full_pp_pops", pop_cnt, 8);
        con_ready = 1'b0;

        // Interrupt countdown
        io_write(8'h88, 8'h0A, 1);
        read_chk("ch0_count", 8'h88, 8'h09);
        io_write(8'h88, 8'h00, 1);
        repeat (15) @(negedge clk);
        read_chk("ch0_cancel", 8'h87, 8'h00);
        io_write(8'h88, 8'h05, 1);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 5) check("int_n_before", int_n, 1);
            if (j == 6) check("int_n_at5", int_n, 0);
        end
        read_chk("pend_status", 8'h85, 8'h08);
        io_write(8'h88, 8'h02, 1);
        io_write(8'h86, 8'h01, 1);
        read_chk("set_wins", 8'h87, 8'h01);
        check("set_wins_int_n", int_n, 0);
        io_write(8'h86, 8'h01, 1);
        @(negedge clk);
        check("ack_int_n", int_n, 1);
        io_write(8'h89, 8'h03, 1);
        repeat (5) @(negedge clk);
        read_chk("ch1_pending", 8'h87, 8'h02);
        io_write(8'h86, 8'h02, 1);
        read_chk("ch1_ack", 8'h87, 8'h00);

`ifdef ENV_IO_MULTI_TIMEOUT_EN
        read_chk("wd_ctl_rst", 8'h82, 8'h01);
        read_chk("wd_max_lo", 8'h83, 8'h10);
        read_chk("wd_max_hi", 8'h84, 8'h27);
        io_write(8'h82, 8'h02, 1);
        io_write(8'h83, 8'd20, 1);
        io_write(8'h84, 8'h00, 1);
        base = fail_cnt;
        io_write(8'h82, 8'h01, 1);
        k = 0;
        while (!timeout_err && k < 60) begin
            @(negedge clk); k++;
        end
        check("wd_expire_cycle", k, 22);
        check("wd_err", timeout_err, 1);
        repeat (10) @(negedge clk);
        check("wd_single_fail", fail_cnt - base, 1);
        io_write(8'h82, 8'h02, 1);
        io_write(8'h85, 8'h01, 1);
        read_chk("wd_err_clr", 8'h85, 8'h00);
        for (int i = 0; i < 30; i++) io_write(8'h82, 8'h03, 1);
        check("wd_no_expire", timeout_err, 0);
        io_write(8'h82, 8'h02, 1);
`else
        read_chk("wd_off2", 8'h82, 8'h00);
        read_chk("wd_off4", 8'h84, 8'h00);
        read_chk("wd_off12", 8'h8C, 8'h00);
        io_write(8'h83, 8'h55, 1);
        read_chk("wd_off3_wr", 8'h83, 8'h00);
        check("wd_err_tied", timeout_err, 0);
`endif

        // Reset in the middle of a write strobe
        base = pass_cnt;
        @(posedge clk); #2;
        addr = 8'h80; DO = 8'h01; iorq_n = 1'b0; wr_n = 1'b0; reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2; reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #2; iorq_n = 1'b1; wr_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_wr", pass_cnt - base, 0);
        read_chk("rst_mid_status", 8'h85, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/env_io_multi.md
ENV_IO_MULTI -- requirements
Module: env_io_multi

Interface
REQ-001 Parameter BASE_ADDR, default 8'h80: I/O window base; the block decodes addr[7:4] == BASE_ADDR[7:4], offsets addr[3:0].
REQ-002 Parameter NUM_INT, default 2, legal 1..8: number of interrupt countdown channels.
REQ-003 Parameter BUF_DEPTH, default 16, power of two, 4..256: console FIFO depth.
REQ-004 Parameter TIMEOUT_W, default 16, legal 16..32: watchdog counter width.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 iorq_n, rd_n, wr_n  input  1 each  Z80 I/O strobes, active-low.
REQ-008 addr  input  8  I/O port address.
REQ-009 DO  input  8  CPU write data.
REQ-010 DI  inout  8  CPU read data; driven only while !iorq_n & !rd_n & window hit, else high-Z.
REQ-011 int_n  output  1  interrupt request, active-low.
REQ-012 test_pass, test_fail, dump_on, dump_off  output  1 each  single-cycle command pulses.
REQ-013 timeout_err  output  1  sticky watchdog-expired flag.
REQ-014 con_data  output  8, con_valid  output  1, con_ready  input  1  console byte stream.

Function
REQ-015 Write access = first cycle of (!iorq_n & !wr_n & hit) after it was false; exactly one register write per I/O cycle regardless of strobe length.
REQ-016 Offset 0 write: DO 1/2/3/4 pulses test_pass/test_fail/dump_on/dump_off the following cycle; any other value sets sticky cmd_err.
REQ-017 Offset 1 write: push DO into console FIFO; if full, drop byte and set sticky ovf. Offset 1 read: FIFO occupancy (saturates at 255).
REQ-018 Console output: con_valid = FIFO not empty; con_data = head byte; byte pops on cycle with con_valid & con_ready; push and pop in same cycle when full: pop first, push accepted, no ovf.
REQ-019 Offset 2: timeout_ctl; bit0 count enable, bit1 clear (self-clearing, reads 0). Offsets 3/4: max_timeout bytes [7:0]/[15:8]; for TIMEOUT_W>16 offsets 12/13 hold [23:16]/[31:24] and max_timeout bits above TIMEOUT_W are ignored.
REQ-020 Watchdog: clear wins over enable; when enabled cur increments by 1 per cycle, saturates at all-ones; when cur >= max_timeout, timeout_err sets and test_fail pulses once (on the rising of timeout_err only).
REQ-021 Offset 8+n (n<NUM_INT) write N: load channel n counter; N=0 cancels; counter decrements each cycle; on the cycle the counter equals 1 it becomes 0 and pending[n] sets, so pending is visible N cycles after the write cycle.
REQ-022 Offset 6 write: pending &= ~DO (write-1-to-clear). Set and clear of the same bit in one cycle: set wins.
REQ-023 Offset 7 read: pending[NUM_INT-1:0], upper bits 0. int_n = ~|pending, registered.
REQ-024 Offset 5 read status: bit0 timeout_err, bit1 ovf, bit2 cmd_err, bit3 |pending, bits7:4 0; write 1s clear bits0..2 (timeout_err re-sets next cycle if condition persists).
REQ-025 Offset 8+n reads: remaining count. Unmapped offsets read 8'hFF, writes ignored.

Reset
REQ-026 reset_n low at posedge: FIFO empty, con_valid 0, all counters 0, pending 0, int_n 1, all pulses 0, sticky flags 0, timeout_ctl 8'h01, max_timeout 10000, cur 0.
REQ-027 Reset mid-I/O-cycle: the ongoing access is discarded; a strobe still low after reset release is not a new write.

Configuration
REQ-028 Macro ENV_IO_MULTI_TIMEOUT_EN: defined -> watchdog per REQ-019/020; undefined -> no watchdog logic, offsets 2/3/4/12/13 read 8'h00, writes ignored, timeout_err tied 0.

Verification
REQ-029 Write 8'h01 to 8'h80 holding wr_n low 5 cycles -> exactly one test_pass pulse, no test_fail.
REQ-030 Write "HI\n" to 8'h81 with con_ready 0, then read 8'h81 -> 3; raise con_ready -> 48,49,0A out in order, con_valid drops after third.
REQ-031 BUF_DEPTH=4, con_ready 0, write 5 bytes -> fifth dropped, status read 8'h02; write 8'h02 to 8'h85 -> status 8'h00.
REQ-032 Write 8'h05 to 8'h88 -> int_n low 5 cycles after write cycle; write 8'h01 to 8'h86 -> int_n high next cycle.
REQ-033 Max_timeout 20, ctl 1 -> timeout_err and single test_fail at cur=20; ctl 8'h03 each cycle -> never expires.
REQ-034 Counter on ch0 reaching 1 in the same cycle as ack 8'h01 -> pending[0] remains 1, int_n low.
